host_cmd_arbiter: RTL and testbench
===================================

// Module: host_cmd_arbiter
// PURPOSE
//  Shares the host RX command pipeline (host_specific_top_rx_from_host) between two
//  command sources: req0 = host link, req1 = local sensor poller (e.g. READ_YAW).
//  Round-robin arbitrates, drives the pipeline's input_data/send_packet, waits for
//  its done/error and returns per-requester completion status, with a timeout.
// PARAMETERS
//  DATA_W          1024  command word width; matches pipeline input_data
//  TIMEOUT_CYCLES  256   max WAIT cycles before abort; legal range 2..65535
//  CNT_W           16    timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk          in   1       single clock; all logic on rising edge
//  reset        in   1       asynchronous, active-low reset
//  req0_valid   in   1       requester 0 command pending; held until req0_done
//  req0_data    in   DATA_W  requester 0 command; stable while req0_valid
//  req0_done    out  1       1-cycle pulse: requester 0 command finished
//  req0_error   out  1       valid with req0_done: pipeline error or timeout
//  req1_valid   in   1       requester 1 command pending (same rules as req0)
//  req1_data    in   DATA_W  requester 1 command
//  req1_done    out  1       1-cycle pulse: requester 1 command finished
//  req1_error   out  1       valid with req1_done
//  input_data   out  DATA_W  to pipeline; latched command during ISSUE, else 0
//  send_packet  out  1       to pipeline; 1-cycle start pulse
//  dut_done     in   1       from pipeline done
//  dut_error    in   1       from pipeline error; sampled with dut_done
//  busy         out  1       1 in any state except IDLE
//  timeout      out  1       1-cycle pulse (in RESP) when the WAIT timeout fired
// BEHAVIOUR
//  - All outputs registered. Reset (reset=0, async): state=IDLE, all outputs 0,
//    counter 0, cmd register 0, last_grant=1 (so req0 wins first tie).
//  - FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE: if neither valid, stay. If one valid, grant it. If both, grant the one
//    != last_grant. On grant: latch reqN_data into cmd reg, store grant id, -> ISSUE.
//  - ISSUE (exactly 1 cycle): send_packet=1, input_data=cmd reg; clear counter; -> WAIT.
//    Latency: valid sampled in IDLE cycle t -> send_packet high in cycle t+1.
//  - WAIT: input_data=0, send_packet=0; counter++ each cycle.
//    dut_done=1 -> err=dut_error, -> RESP. Else counter==TIMEOUT_CYCLES-1 ->
//    err=1, to_flag=1, -> RESP. dut_done on the timeout cycle wins (not a timeout).
//  - RESP (1 cycle): reqG_done=1, reqG_error=err, timeout=to_flag for granted G
//    only; last_grant=G; -> IDLE. dut_done in cycle k of WAIT -> reqG_done in k+1.
//  - dut_done/dut_error outside WAIT are ignored (no state change, no output).
//  - Requester drops valid on the edge it samples done; a requester holding valid
//    after done is treated as a new command next IDLE.
//  - Changes to reqN_data/valid after grant do not affect the command in flight.
//  - Reset mid-operation: abort immediately, no done pulse for the aborted command.
//  - Minimum turnaround per command: 4 cycles (IDLE, ISSUE, 1 WAIT, RESP).
// TESTING
//  1 Reset: hold reset=0 4 cycles -> all outputs 0, busy=0; release, no valids ->
//    send_packet stays 0 for 20 cycles.
//  2 req0 with 72'h0101FFFFFFFFFFFF01, dut_done after 5 WAIT cycles, dut_error=0 ->
//    one send_packet pulse, input_data==cmd that cycle and 0 after, req0_done=1,
//    req0_error=0, req1_done never.
//  3 req0 and req1 asserted together, repeatedly (3 rounds each) -> service order
//    0,1,0,1,0,1; each input_data matches its requester's data.
//  4 req1 with 56'hFF27FF27FF2705 (invalid cmd), dut_done with dut_error=1 ->
//    req1_done=1, req1_error=1, timeout=0.
//  5 TIMEOUT_CYCLES=16, req0 valid, dut_done never -> req0_done/req0_error/timeout
//    all high exactly 16 cycles after WAIT entry; then IDLE; spurious dut_done in
//    IDLE ignored.
//  6 Reset asserted mid-WAIT -> outputs 0 asynchronously; after release a new req1
//    command (56'hFF27FF27FF2703) completes normally with req1_error=0.

Source files
------------

// File: rtl/host_cmd_arbiter_if.sv
// Bundle of requester, pipeline and status signals around host_cmd_arbiter.
// The slave side is the arbiter. The master side is whatever drives the requesters and the pipeline.
interface host_cmd_arbiter_if #(
  parameter int DATA_W = 1024
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_done;
  logic              req0_error;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_done;
  logic              req1_error;
  logic [DATA_W-1:0] input_data;
  logic              send_packet;
  logic              dut_done;
  logic              dut_error;
  logic              busy;
  logic              timeout;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, dut_done, dut_error,
    output req0_done, req0_error, req1_done, req1_error,
           input_data, send_packet, busy, timeout
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, dut_done, dut_error,
    input  req0_done, req0_error, req1_done, req1_error,
           input_data, send_packet, busy, timeout
  );
endinterface

// File: rtl/host_cmd_arbiter.sv
// Round-robin arbiter that shares the host RX command pipeline between the host link (req0)
// and the local sensor poller (req1), with per-command completion status and a WAIT timeout.
module host_cmd_arbiter #(
  parameter int DATA_W         = 1024,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic            clk,
  input  logic            reset,
  host_cmd_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              resp_err, resp_to;

  // input_data_q is the command register. It holds the granted word only for the ISSUE cycle.
  logic [DATA_W-1:0] input_data_q, input_data_d;
  logic              send_q, send_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              err0_q, err0_d;
  logic              err1_q, err1_d;
  logic              to_q, to_d;
  logic              busy_q, busy_d;

  // NOTE: sequential state uses non-blocking assignments only, so that every register
  // samples the values from before the edge, whatever order the processes run in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every variable written here gets a default first, so that no path infers a latch.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    input_data_d = '0;
    resp_err     = 1'b0;
    resp_to      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          // When both requesters are valid, the one that was not served last wins.
          grant_d      = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
          input_data_d = grant_d ? bus.req1_data : bus.req0_data;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.dut_done) begin
          resp_err = bus.dut_error;
          state_d  = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          resp_err = 1'b1;
          resp_to  = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so that they come straight out of flops.
    send_d  = (state_d == S_ISSUE);
    busy_d  = (state_d != S_IDLE);
    done0_d = (state_d == S_RESP) && !grant_q;
    done1_d = (state_d == S_RESP) &&  grant_q;
    err0_d  = done0_d && resp_err;
    err1_d  = done1_d && resp_err;
    to_d    = (state_d == S_RESP) && resp_to;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      input_data_q <= '0;
      send_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      to_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      input_data_q <= input_data_d;
      send_q       <= send_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      to_q         <= to_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.input_data  = input_data_q;
  assign bus.send_packet = send_q;
  assign bus.req0_done   = done0_q;
  assign bus.req0_error  = err0_q;
  assign bus.req1_done   = done1_q;
  assign bus.req1_error  = err1_q;
  assign bus.timeout     = to_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_host_cmd_arbiter.sv
// Self-checking bench for host_cmd_arbiter: directed table, hand-written reset and spurious-done
// sequences, then random traffic against a transaction-level round-robin model.
module tb_host_cmd_arbiter;

  localparam int DW = 128;
  localparam int T  = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  host_cmd_arbiter_if #(.DATA_W(DW)) bus ();

  host_cmd_arbiter #(
    .DATA_W        (DW),
    .TIMEOUT_CYCLES(T),
    .CNT_W         (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit            v0;
    bit            v1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    int            delay;   // WAIT cycle index of dut_done; >= T means never
    bit            derr;
    bit            exp_g;
    bit            exp_err;
    bit            exp_to;
  } vec_t;

  vec_t tbl [12];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   m_last   = 1'b1;  // model of last served requester

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the arbiter idle. Returns at the negedge of the following IDLE cycle.
  task automatic do_cmd(input bit v0, input bit v1, input logic [DW-1:0] d0,
                        input logic [DW-1:0] d1, input int delay, input bit derr,
                        input bit eg, input bit eerr, input bit eto);
    int k;
    int n;
    int noise;
    bit got;
    logic [DW-1:0] exp_d;
    exp_d = eg ? d1 : d0;
    bus.req0_valid = v0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_data  = d1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.send_packet && k < 4);
    check("issue_latency", k, 1);
    check("issue_data", bus.input_data, exp_d);
    check("issue_busy", bus.busy, 1);
    // Requester data may change after the grant without touching the command in flight.
    bus.req0_data = ~d0;
    bus.req1_data = ~d1;
    got = 1'b0;
    n = -1;
    noise = 0;
    for (int i = 0; i < T + 4 && !got; i++) begin
      @(negedge clk);
      bus.dut_done  = 1'b0;
      bus.dut_error = 1'b0;
      if (bus.req0_done || bus.req1_done) begin
        got = 1'b1;
        n = i;
      end else begin
        if (bus.send_packet || bus.input_data != '0 || !bus.busy) noise++;
        if (i == delay) begin
          bus.dut_done  = 1'b1;
          bus.dut_error = derr;
        end
      end
    end
    check("wait_quiet", noise, 0);
    check("done_latency", n, (delay < T) ? delay + 1 : T);
    check("done0", bus.req0_done, !eg);
    check("done1", bus.req1_done, eg);
    check("error", eg ? bus.req1_error : bus.req0_error, eerr);
    check("other_error", eg ? bus.req0_error : bus.req1_error, 0);
    check("timeout", bus.timeout, eto);
    if (eg) bus.req1_valid = 1'b0;
    else    bus.req0_valid = 1'b0;
    @(negedge clk);
    check("resp_pulse_end", {bus.req0_done, bus.req1_done, bus.timeout, bus.busy}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    bit v0, v1, g, derr;
    int delay;
    logic [DW-1:0] d0, d1;

    tbl[0]  = '{1'b1, 1'b0, DW'(72'h0101FFFFFFFFFFFF01), '0, 5, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, '0, DW'(56'hFF27FF27FF2705), 2, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int r = 0; r < 6; r++)
      tbl[2 + r] = '{1'b1, 1'b1, DW'(32'hA0 + r), DW'(32'hB0 + r), r, 1'b0,
                     bit'(r % 2), 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, DW'(32'h5EED), '0, 1000, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, '0, DW'(32'h7777), T - 1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, DW'(32'h1234), '0, 0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, DW'(32'hC0DE), DW'(32'hBEEF), T - 2, 1'b1, 1'b1, 1'b1, 1'b0};

    bus.req0_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = '0;
    bus.dut_done   = 1'b0;
    bus.dut_error  = 1'b0;

    // Reset state, then a quiet idle period with no requesters.
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_outputs", {bus.busy, bus.send_packet, bus.req0_done, bus.req0_error,
                            bus.req1_done, bus.req1_error, bus.timeout}, 0);
    check("reset_data", bus.input_data, 0);
    reset = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.send_packet || bus.busy) bad++;
    end
    check("idle_quiet", bad, 0);

    for (int i = 0; i < 12; i++) begin
      do_cmd(tbl[i].v0, tbl[i].v1, tbl[i].d0, tbl[i].d1, tbl[i].delay, tbl[i].derr,
             tbl[i].exp_g, tbl[i].exp_err, tbl[i].exp_to);
      m_last = tbl[i].exp_g;
      if (i == 8) begin
        // A stray pipeline done while idle must be ignored.
        bus.dut_done  = 1'b1;
        bus.dut_error = 1'b1;
        bad = 0;
        repeat (3) begin
          @(negedge clk);
          if (bus.busy || bus.send_packet || bus.req0_done || bus.req1_done || bus.timeout) bad++;
        end
        bus.dut_done  = 1'b0;
        bus.dut_error = 1'b0;
        check("spurious_done_ignored", bad, 0);
      end
    end

    // Reset in the middle of WAIT aborts the command without a done pulse.
    bus.req0_valid = 1'b1;
    bus.req0_data  = DW'(32'hDEAD);
    @(negedge clk);
    check("abort_issue", bus.send_packet, 1);
    repeat (3) @(negedge clk);
    check("abort_busy_before", bus.busy, 1);
    #2 reset = 1'b0;
    #1;
    check("abort_outputs", {bus.busy, bus.send_packet, bus.req0_done, bus.req1_done,
                            bus.timeout}, 0);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    check("abort_no_done", {bus.req0_done, bus.req0_error}, 0);
    reset = 1'b1;
    m_last = 1'b1;
    do_cmd(1'b0, 1'b1, '0, DW'(56'hFF27FF27FF2703), 3, 1'b0, 1'b1, 1'b0, 1'b0);
    m_last = 1'b1;

    // Random traffic against the round-robin and timeout rules.
    for (int r = 0; r < 40; r++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      g = (v0 && v1) ? !m_last : v1;
      delay = $urandom_range(0, 20);
      derr  = 1'($urandom_range(0, 1));
      d0 = {$urandom, $urandom, $urandom, $urandom};
      d1 = {$urandom, $urandom, $urandom, $urandom};
      do_cmd(v0, v1, d0, d1, delay, derr, g, (delay < T) ? derr : 1'b1, delay >= T);
      m_last = g;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
